// File: rtl/sat_engine_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sat_engine_ctrl
// Purpose  : Sequencing FSM for the Sat Engine variable state list: drives the
//            decide/imply/analyze/backtrack strobes and owns the decision level.
//            Optional analyze watchdog enabled by defining SAT_CTRL_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sat_engine_ctrl #(
    parameter int WIDTH_LVL    = 16,
    parameter int IMPLY_SETTLE = 2,
    parameter int WIDTH_SETTLE = 2,
    parameter int ANALYZE_MAX  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH_LVL-1:0] load_lvl_i,
    output logic                 dec_req_o,
    input  logic                 dec_valid_i,
    input  logic                 dec_none_i,
    output logic                 apply_imply_o,
    input  logic                 find_imply_i,
    input  logic                 find_conflict_i,
    output logic                 apply_analyze_o,
    input  logic                 analyze_done_i,
    input  logic [WIDTH_LVL-1:0] max_lvl_i,
    output logic                 apply_bkt_o,
    output logic [WIDTH_LVL-1:0] bkt_lvl_o,
    output logic [WIDTH_LVL-1:0] cur_lvl_o,
    output logic                 done_o,
    output logic [1:0]           result_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_IMPLY   = 3'd1,
        S_DECIDE  = 3'd2,
        S_ANALYZE = 3'd3,
        S_BKT     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [1:0]              c_res_sat    = 2'b01;
    localparam logic [1:0]              c_res_unsat  = 2'b10;
    localparam logic [WIDTH_LVL-1:0]    c_lvl_max    = '1;
    localparam logic [WIDTH_SETTLE-1:0] c_quiet_last = WIDTH_SETTLE'(IMPLY_SETTLE - 1);

`ifdef SAT_CTRL_WATCHDOG_EN
    localparam logic [1:0]         c_res_wdog = 2'b11;
    localparam int                 c_ana_w    = $clog2(ANALYZE_MAX + 1);
    localparam logic [c_ana_w-1:0] c_ana_last = c_ana_w'(ANALYZE_MAX - 1);
    logic [c_ana_w-1:0]            r_ana_cnt;
`endif

    // Quiet counter must be able to count up to IMPLY_SETTLE-1.
    if (IMPLY_SETTLE < 1 || ANALYZE_MAX < 1 ||
        (1 << WIDTH_SETTLE) <= (IMPLY_SETTLE - 1)) begin : g_bad_cfg
        $error("sat_engine_ctrl: invalid parameter set");
    end

    state_t                  r_state;
    logic [WIDTH_SETTLE-1:0] r_quiet;
    logic [WIDTH_LVL-1:0]    r_cur_lvl;
    logic [WIDTH_LVL-1:0]    r_bkt_lvl;
    logic [1:0]              r_result;
    logic                    r_dec_req;
    logic                    r_imply;
    logic                    r_analyze;
    logic                    r_bkt;
    logic                    r_done;
    logic                    r_busy;

    // Strobes are registered from the state being entered, so each one is
    // high exactly while the FSM sits in its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_quiet   <= '0;
            r_cur_lvl <= '0;
            r_bkt_lvl <= '0;
            r_result  <= 2'b00;
            r_dec_req <= 1'b0;
            r_imply   <= 1'b0;
            r_analyze <= 1'b0;
            r_bkt     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef SAT_CTRL_WATCHDOG_EN
            r_ana_cnt <= '0;
`endif
        end else begin
            r_dec_req <= 1'b0;
            r_imply   <= 1'b0;
            r_analyze <= 1'b0;
            r_bkt     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_busy <= start_i;
                    if (start_i) begin
                        r_cur_lvl <= load_lvl_i;
                        r_result  <= 2'b00;
                        r_quiet   <= '0;
                        r_imply   <= 1'b1;
                        r_state   <= S_IMPLY;
                    end
                end
                S_IMPLY: begin
                    if (find_conflict_i && (r_cur_lvl == '0)) begin
                        r_result <= c_res_unsat;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (find_conflict_i) begin
                        r_analyze <= 1'b1;
                        r_state   <= S_ANALYZE;
`ifdef SAT_CTRL_WATCHDOG_EN
                        r_ana_cnt <= '0;
`endif
                    end else if (find_imply_i) begin
                        r_quiet <= '0;
                        r_imply <= 1'b1;
                    end else if (r_quiet == c_quiet_last) begin
                        r_quiet   <= '0;
                        r_dec_req <= 1'b1;
                        r_state   <= S_DECIDE;
                    end else begin
                        r_quiet <= r_quiet + 1'b1;
                        r_imply <= 1'b1;
                    end
                end
                S_DECIDE: begin
                    if (dec_none_i) begin
                        r_result <= c_res_sat;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (dec_valid_i) begin
                        if (r_cur_lvl != c_lvl_max) begin
                            r_cur_lvl <= r_cur_lvl + 1'b1;
                        end
                        r_quiet <= '0;
                        r_imply <= 1'b1;
                        r_state <= S_IMPLY;
                    end else begin
                        r_dec_req <= 1'b1;
                    end
                end
                S_ANALYZE: begin
                    if (analyze_done_i) begin
                        r_bkt_lvl <= max_lvl_i;
                        r_bkt     <= 1'b1;
                        r_state   <= S_BKT;
`ifdef SAT_CTRL_WATCHDOG_EN
                    end else if (r_ana_cnt == c_ana_last) begin
                        r_result <= c_res_wdog;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_ana_cnt <= r_ana_cnt + 1'b1;
                        r_analyze <= 1'b1;
                    end
`else
                    end else begin
                        r_analyze <= 1'b1;
                    end
`endif
                end
                S_BKT: begin
                    // A backtrack to level 0 is still issued; UNSAT shows up on
                    // the next conflict seen at level 0.
                    r_cur_lvl <= r_bkt_lvl;
                    r_quiet   <= '0;
                    r_imply   <= 1'b1;
                    r_state   <= S_IMPLY;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dec_req_o       = r_dec_req;
    assign apply_imply_o   = r_imply;
    assign apply_analyze_o = r_analyze;
    assign apply_bkt_o     = r_bkt;
    assign bkt_lvl_o       = r_bkt_lvl;
    assign cur_lvl_o       = r_cur_lvl;
    assign done_o          = r_done;
    assign result_o        = r_result;
    assign busy_o          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sat_engine_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sat_engine_ctrl
// Purpose  : Randomized scoreboard bench for sat_engine_ctrl (phase-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sat_engine_ctrl;

    localparam int W       = 16;
    localparam int SETTLE  = 2;
    localparam int ANA_MAX = 64;
    localparam int NPH     = 64;
    localparam int K_IDLE = 0, K_IMP = 1, K_DEC = 2, K_ANA = 3, K_BKT = 4, K_DONE = 5;
`ifdef SAT_CTRL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] load_lvl_i = '0;
    logic         dec_valid_i = 1'b0;
    logic         dec_none_i = 1'b0;
    logic         find_imply_i = 1'b0;
    logic         find_conflict_i = 1'b0;
    logic         analyze_done_i = 1'b0;
    logic [W-1:0] max_lvl_i = '0;
    logic         dec_req_o, apply_imply_o, apply_analyze_o, apply_bkt_o, done_o, busy_o;
    logic [W-1:0] bkt_lvl_o, cur_lvl_o;
    logic [1:0]   result_o;

    always #5 clk = ~clk;

    sat_engine_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .load_lvl_i(load_lvl_i),
        .dec_req_o(dec_req_o), .dec_valid_i(dec_valid_i), .dec_none_i(dec_none_i),
        .apply_imply_o(apply_imply_o), .find_imply_i(find_imply_i),
        .find_conflict_i(find_conflict_i), .apply_analyze_o(apply_analyze_o),
        .analyze_done_i(analyze_done_i), .max_lvl_i(max_lvl_i),
        .apply_bkt_o(apply_bkt_o), .bkt_lvl_o(bkt_lvl_o), .cur_lvl_o(cur_lvl_o),
        .done_o(done_o), .result_o(result_o), .busy_o(busy_o)
    );

    // One expected phase: which strobe, how many cycles, level shown, extras.
    typedef struct {
        int           kind;
        int           len;
        logic [W-1:0] lvl;
        logic [W-1:0] aux;
        logic [1:0]   res;
    } ev_t;

    ev_t  expq[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    bit   m_idle_bad = 1'b0;
    logic [1:0] exp_final_res;

    // Per-run environment plan, consumed phase by phase.
    logic [31:0]  imp_bits [NPH];
    int           conf_at  [NPH];
    int           dec_delay[NPH];
    int           dec_kind [NPH];   // 0 valid, 1 none, 2 none+valid
    int           an_len   [NPH];
    logic [W-1:0] an_max   [NPH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int len, input logic [W-1:0] lvl,
                           input logic [W-1:0] aux, input logic [1:0] res);
        ev_t e;
        e.kind = kind; e.len = len; e.lvl = lvl; e.aux = aux; e.res = res;
        expq.push_back(e);
    endtask

    function automatic int classify();
        if (done_o)          return K_DONE;
        if (apply_bkt_o)     return K_BKT;
        if (apply_analyze_o) return K_ANA;
        if (dec_req_o)       return K_DEC;
        if (apply_imply_o)   return K_IMP;
        return K_IDLE;
    endfunction

    // Build a random plan and walk it at phase level to predict the run.
    task automatic gen_and_model(input logic [W-1:0] l0, input int min_dec,
                                 input bit allow_conf, input bit force_wd);
        logic [W-1:0] lvl;
        int ip, dp, ap, q, n, r;
        bit fin, conf;
        for (int i = 0; i < NPH; i++) begin
            r = $urandom_range(0, 2);
            if (r == 0)      imp_bits[i] = 32'h0;
            else if (r == 1) imp_bits[i] = 32'h0000_0555;
            else             imp_bits[i] = $urandom & 32'h0000_0FFF;
            conf_at[i]   = (allow_conf && i < 40 && $urandom_range(0, 2) == 0) ?
                           int'($urandom_range(0, 5)) : -1;
            dec_delay[i] = $urandom_range(1, 3);
            r = $urandom_range(0, 7);
            if (min_dec < 0 && i == 0) dec_kind[i] = 1;
            else if (i < min_dec)      dec_kind[i] = 0;
            else if (i >= 6)           dec_kind[i] = $urandom_range(1, 2);
            else                       dec_kind[i] = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            an_len[i] = $urandom_range(1, 6);
            an_max[i] = '0;
        end
        if (force_wd) begin
            conf_at[0] = 0;
            an_len[0]  = ANA_MAX + 6;
        end
        lvl = l0; ip = 0; dp = 0; ap = 0; fin = 1'b0;
        while (!fin) begin
            q = 0; n = 0; conf = 1'b0;
            for (int c = 0; c < 64; c++) begin
                n = c + 1;
                if (c == conf_at[ip]) begin conf = 1'b1; break; end
                if (c < 32 && imp_bits[ip][c]) q = 0;
                else q++;
                if (q == SETTLE) break;
            end
            push_ev(K_IMP, n, lvl, '0, 2'b00);
            ip++;
            if (conf) begin
                if (lvl == '0) begin
                    push_ev(K_DONE, 1, lvl, '0, 2'b10);
                    exp_final_res = 2'b10; fin = 1'b1;
                end else if (WD_EN && an_len[ap] > ANA_MAX) begin
                    push_ev(K_ANA, ANA_MAX, lvl, '0, 2'b00);
                    push_ev(K_DONE, 1, lvl, '0, 2'b11);
                    exp_final_res = 2'b11; fin = 1'b1;
                end else begin
                    an_max[ap] = (lvl > 4) ? W'($urandom_range(0, 3)) :
                                             W'($urandom_range(0, int'(lvl) - 1));
                    push_ev(K_ANA, an_len[ap], lvl, '0, 2'b00);
                    push_ev(K_BKT, 1, lvl, an_max[ap], 2'b00);
                    lvl = an_max[ap];
                    ap++;
                end
            end else begin
                push_ev(K_DEC, dec_delay[dp], lvl, '0, 2'b00);
                if (dec_kind[dp] != 0) begin
                    push_ev(K_DONE, 1, lvl, '0, 2'b01);
                    exp_final_res = 2'b01; fin = 1'b1;
                end else begin
                    lvl = (lvl == {W{1'b1}}) ? lvl : lvl + 1'b1;
                end
                dp++;
            end
        end
    endtask

    // Monitor: rebuild phases from DUT strobes and score each against the queue.
    int           m_prev = K_IDLE;
    int           m_len = 0;
    logic [W-1:0] m_lvl = '0, m_aux = '0;
    logic [1:0]   m_res = 2'b00;
    bit           m_bad = 1'b0;

    task automatic close_phase();
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $display("FAIL phase_extra: got kind=%0d len=%0d lvl=%0h, required no phase", m_prev, m_len, m_lvl);
        end else begin
            e = expq.pop_front();
            if (e.kind != m_prev || e.len != m_len || e.lvl != m_lvl || e.res != m_res ||
                (e.kind == K_BKT && e.aux != m_aux) || m_bad) begin
                failures++;
                $display("FAIL phase: got kind=%0d len=%0d lvl=%0h bkt=%0h res=%0d bad=%0d, required kind=%0d len=%0d lvl=%0h bkt=%0h res=%0d bad=0",
                         m_prev, m_len, m_lvl, m_aux, m_res, m_bad, e.kind, e.len, e.lvl, e.aux, e.res);
            end
        end
    endtask

    initial begin
        int k, ns;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                m_prev = K_IDLE; m_len = 0;
            end else begin
                k  = classify();
                ns = int'(done_o) + int'(dec_req_o) + int'(apply_imply_o) +
                     int'(apply_analyze_o) + int'(apply_bkt_o);
                if (k != m_prev) begin
                    if (m_prev != K_IDLE) close_phase();
                    m_len = 1; m_lvl = cur_lvl_o; m_bad = 1'b0;
                end else begin
                    m_len++;
                end
                if (k != K_IDLE) begin
                    if (ns > 1 || !busy_o || cur_lvl_o != m_lvl) m_bad = 1'b1;
                    m_aux = bkt_lvl_o; m_res = result_o;
                end else if (busy_o) begin
                    m_idle_bad = 1'b1;
                end
                m_prev = k;
            end
        end
    end

    // Driver: plays the array/decision/analysis helpers against the plan.
    task automatic run_one(input logic [W-1:0] l0, input int min_dec,
                           input bit allow_conf, input bit force_wd);
        int ci, cip, cdp, cap, ipn, dpn, apn, kd, prev_kd, cyc;
        bit seen_done;
        gen_and_model(l0, min_dec, allow_conf, force_wd);
        m_idle_bad = 1'b0;
        @(negedge clk);
        load_lvl_i = l0; start_i = 1'b1;
        prev_kd = K_IDLE; seen_done = 1'b0; cyc = 0;
        ci = 0; cip = 0; cdp = 0; cap = 0; ipn = 0; dpn = 0; apn = 0;
        while (!seen_done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            kd = classify();
            if (kd != prev_kd) begin
                ci = 0;
                if (kd == K_IMP) begin cip = ipn; ipn++; end
                if (kd == K_DEC) begin cdp = dpn; dpn++; end
                if (kd == K_ANA) begin cap = apn; apn++; end
            end else begin
                ci++;
            end
            prev_kd = kd;
            start_i         = (kd != K_IDLE) && ($urandom_range(0, 7) == 0);
            load_lvl_i      = W'($urandom);
            find_imply_i    = 1'($urandom);
            find_conflict_i = 1'($urandom);
            dec_valid_i     = 1'($urandom);
            dec_none_i      = 1'($urandom);
            analyze_done_i  = 1'($urandom);
            max_lvl_i       = W'($urandom);
            if (kd == K_IDLE) begin
                dec_none_i = 1'b0; dec_valid_i = 1'b0;
            end
            case (kd)
                K_IMP: begin
                    find_imply_i    = (ci < 32 && cip < NPH) ? imp_bits[cip][ci] : 1'b0;
                    find_conflict_i = (cip < NPH) && (conf_at[cip] == ci);
                end
                K_DEC: begin
                    dec_valid_i = (cdp < NPH) && (ci == dec_delay[cdp] - 1) && (dec_kind[cdp] != 1);
                    dec_none_i  = (cdp < NPH) && (ci == dec_delay[cdp] - 1) && (dec_kind[cdp] != 0);
                end
                K_ANA: begin
                    analyze_done_i = (cap < NPH) && (ci == an_len[cap] - 1);
                    if (analyze_done_i) max_lvl_i = an_max[cap];
                end
                K_DONE: seen_done = 1'b1;
                default: ;
            endcase
        end
        @(negedge clk);
        start_i = 1'b0; dec_valid_i = 1'b0; dec_none_i = 1'b0; find_imply_i = 1'b0;
        find_conflict_i = 1'b0; analyze_done_i = 1'b0;
        if (!seen_done) begin
            checks++; failures++;
            $display("FAIL run_timeout: got no done_o within %0d cycles, required done_o", cyc);
            mon_en = 1'b0; rst = 1'b1;
            @(negedge clk);
            rst = 1'b0; expq.delete(); mon_en = 1'b1;
        end else begin
            repeat (3) @(negedge clk);
            chk("events_left", expq.size(), 0);
            chk("result_held", {busy_o, result_o}, {1'b0, exp_final_res});
            chk("busy_in_idle", m_idle_bad, 0);
        end
    endtask

    task automatic reset_mid_analyze();
        bit got;
        mon_en = 1'b0;
        @(negedge clk);
        load_lvl_i = 16'd3; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; find_conflict_i = 1'b1;
        @(negedge clk);
        find_conflict_i = 1'b0; analyze_done_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_pre_analyze", {apply_analyze_o, busy_o, cur_lvl_o}, {2'b11, 16'd3});
        #2 rst = 1'b1;
        #1;
        chk("rst_async_strobes", {dec_req_o, apply_imply_o, apply_analyze_o, apply_bkt_o, done_o, busy_o, result_o}, 0);
        chk("rst_async_levels", {bkt_lvl_o, cur_lvl_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        got = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done_o || busy_o) got = 1'b1;
        end
        chk("rst_no_done", got, 0);
        mon_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_strobes", {dec_req_o, apply_imply_o, apply_analyze_o, apply_bkt_o, done_o, busy_o}, 0);
        chk("reset_cur_lvl", cur_lvl_o, 0);
        chk("reset_bkt_lvl", bkt_lvl_o, 0);
        chk("reset_result", result_o, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        run_one(16'd0, -1, 1'b0, 1'b0);
        run_one(16'd0, 2, 1'b0, 1'b0);
        run_one(16'hFFFE, 3, 1'b0, 1'b0);
        run_one(16'd3, 0, 1'b1, 1'b0);
        for (int r = 0; r < 30; r++) begin
            run_one(W'($urandom_range(0, 5)), $urandom_range(0, 3), 1'b1, 1'b0);
        end
        reset_mid_analyze();
`ifdef SAT_CTRL_WATCHDOG_EN
        run_one(16'd2, 0, 1'b0, 1'b1);
`endif
        run_one(16'd1, 1, 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
